// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter-side signal bundle for the UART transmit scheduler.
// master: requesters plus UART transmitter side; slave: the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int DBITS = 3
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DBITS-1:0] din_bus;
  logic [NREQ-1:0]       ack;
  logic                  tx_start;
  logic [DBITS-1:0]      tx_din;
  logic                  tx_done;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  timeout_err;
  logic                  err_clr;

  modport master (
    output req, din_bus, tx_done, err_clr,
    input  ack, tx_start, tx_din, grant_id, busy, timeout_err
  );

  modport slave (
    input  req, din_bus, tx_done, err_clr,
    output ack, tx_start, tx_din, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters,
// with a watchdog that aborts a frame whose tx_done never arrives.
module uart_tx_scheduler #(
  parameter int NREQ    = 4,
  parameter int DBITS   = 3,
  parameter int TIMEOUT = 4095
) (
  input logic               clk,
  input logic               rst,
  uart_tx_scheduler_if.slave bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [DBITS-1:0]  din_q, din_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [15:0]       wdog_q, wdog_d;

  logic              found;
  logic [GW-1:0]     pick;
  int                idx;

  // Search upward from the requester after the last winner, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    din_d   = din_q;
    ack_d   = '0;
    start_d = 1'b0;
    wdog_d  = wdog_q;
    err_d   = err_q;
    if (bus.err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          din_d   = bus.din_bus[int'(pick)*DBITS +: DBITS];
          ack_d   = NREQ'(1) << pick;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        wdog_d = wdog_q + 16'd1;
        // tx_done takes priority over a coincident terminal count
        if (bus.tx_done) begin
          state_d = S_IDLE;
        end else if (wdog_d == 16'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      din_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_din      = din_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter among several CPU-side requesters. It accepts one frame at a time from the requesters and drives the transmitter's start/data handshake. It then waits for the transmitter's completion pulse before granting the next requester. A watchdog flags a transmitter that never completes. The block sits between the CPU-side channel logic and the UART transmit path (tx_start/din/tx_done).

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- DBITS, 3: data bits per frame; matches the UART data width.
- TIMEOUT, 4095: cycles in BUSY without tx_done before abort; legal range 1..65535.
- GW: derived, $clog2(NREQ); not overridable.

- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester frame request; level, held until ack.
- din_bus  in  NREQ*DBITS  requester i data at bits [i*DBITS +: DBITS]; stable while req[i]=1.
- ack  out  NREQ  one-cycle pulse; the frame of requester i has been taken.
- tx_start  out  1  one-cycle start pulse to the UART transmitter.
- tx_din  out  DBITS  frame data to the transmitter; valid and held from tx_start until return to IDLE.
- tx_done  in  1  one-cycle completion pulse from the transmitter.
- grant_id  out  GW  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err for one cycle.

## Operation
- The FSM has three states: IDLE, START and BUSY. All outputs are registered.
- **IDLE:** if req≠0, pick the first set bit searching upward from (last+1) mod NREQ, wrapping around.
  - Register the winner into grant_id and last, latch its din_bus slice into tx_din, and go to START.
- **START:** assert tx_start=1 and ack[grant_id]=1 for exactly this cycle. Clear the watchdog and go to BUSY.
- **BUSY:** the watchdog increments each cycle.
  - tx_done=1 → IDLE.
  - Otherwise, when the watchdog reaches TIMEOUT → set timeout_err and go to IDLE (abort). The aborted frame is not retried.
- tx_done in IDLE or START is ignored.
- tx_done and watchdog terminal count in the same cycle: tx_done wins; timeout_err is not set.
- A req still high after its ack is a new request. Round-robin guarantees that every other active requester is served first.
- Requests arriving in START or BUSY wait; they are evaluated only in IDLE.
- A single active requester is granted back-to-back.
- err_clr clears timeout_err. If err_clr and a new timeout coincide, set wins.
- Watchdog width: 16 bits, compared with equality to TIMEOUT. It is not wrapped, because the state exits at TIMEOUT.

## Timing
- **Reset values:** state=IDLE, ack=0, tx_start=0, tx_din=0, grant_id=0, busy=0, timeout_err=0, watchdog=0, last=NREQ-1, so requester 0 is highest priority after reset.
- **Reset mid-frame:** it is an immediate abort. No ack, tx_start or error is generated afterward.
- **Request latency:** req rises and is sampled in IDLE at cycle n. grant_id and tx_din are valid at n+1, together with tx_start and ack.
- **Completion:** tx_done at cycle k → busy=0 at k+1. The next tx_start is no earlier than k+2.
- **Timeout:** tx_start at cycle s with no tx_done → timeout_err=1 and busy=0 at s+TIMEOUT+1.
- **Frame occupancy:** minimum 3 cycles per frame (IDLE, START, BUSY with immediate tx_done).
- **Output stability:** ack and tx_start are never asserted outside START and are always coincident.

## Test plan
- **Reset priority:** after reset, req=4'b1111 with data 1,2,3,4 on requesters 0..3, tx_done 5 cycles after each tx_start.
  - Grants go 0,1,2,3,0.
  - tx_din goes 1,2,3,4,1.
  - Each ack aligns with its tx_start.
- **Fairness:** req=4'b1010 held continuously → grants alternate 1,3,1,3. Requesters 0 and 2 never acked.
- **Back-to-back:** req[2] only, tx_done one cycle after tx_start → tx_start every 3 cycles, grant_id=2 throughout.
- **Watchdog:** TIMEOUT=8, no tx_done.
  - timeout_err=1 and busy=0 nine cycles after tx_start.
  - The next request is granted normally.
  - err_clr pulse → timeout_err=0.
- **Coincidence:** tx_done on the watchdog terminal cycle → timeout_err stays 0. Also, tx_done pulsed in IDLE → no state change.
- **Reset mid-frame:** rst asserted in BUSY → next cycle all outputs are at reset values. req=4'b1000 then grants requester 3 with tx_start two cycles after rst is released.
